// File: rtl/sys_id_mbank.sv
// sys_id_mbank: system-ID register block with NUM_BANKS multi-cycle read-only ROM banks.
// Optional macro SYSID_UPTIME_EN adds a 64-bit uptime counter at offsets 0x04/0x05.

module sys_id_mbank #(
    parameter int ROM_WIDTH     = 32,
    parameter int ROM_ADDR_BITS = 6,
    parameter int NUM_BANKS     = 2,
    parameter int ROM_LATENCY   = 1,
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                           up_clk,
    input  logic                           up_rstn,
    input  logic                           up_wreq,
    input  logic [ADDRESS_WIDTH-1:0]       up_waddr,
    input  logic [31:0]                    up_wdata,
    output logic                           up_wack,
    input  logic                           up_rreq,
    input  logic [ADDRESS_WIDTH-1:0]       up_raddr,
    output logic [31:0]                    up_rdata,
    output logic                           up_rack,
    output logic [ROM_ADDR_BITS-1:0]       rom_addr,
    output logic [NUM_BANKS-1:0]           rom_rd,
    input  logic [NUM_BANKS*ROM_WIDTH-1:0] rom_data
);

    localparam logic [31:0] VERSION_WORD  = 32'h00020000;
    localparam logic [31:0] MAGIC_WORD    = 32'h53594944;
    localparam logic [31:0] UNMAPPED_WORD = 32'hDEADDEAD;
    localparam logic [31:0] CONFIG_WORD   = {8'd0, 8'(NUM_BANKS), 8'(ROM_ADDR_BITS), 8'(ROM_LATENCY)};
    localparam logic [2:0]  BANK_COUNT    = 3'(NUM_BANKS);
    localparam logic [2:0]  WAIT_LOAD     = 3'(ROM_LATENCY);
    localparam logic [31:0] OFF_SCRATCH   = 32'd2;
    localparam logic [31:0] OFF_RD_ERR    = 32'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } rd_state_t;

    rd_state_t                state_r, state_nxt_s;
    logic [2:0]               cnt_r, cnt_nxt_s;
    logic                     rack_r, rack_nxt_s;
    logic [31:0]              rdata_r, rdata_nxt_s;
    logic [NUM_BANKS-1:0]     rom_rd_r, rom_rd_nxt_s;
    logic [ROM_ADDR_BITS-1:0] rom_addr_r, rom_addr_nxt_s;
    logic [2:0]               sel_bank_r, sel_bank_nxt_s;
    logic                     wack_r;
    logic [31:0]              scratch_r;
    logic [15:0]              rd_err_r;

    logic [2:0]               rbank_s, wbank_s, rom_bank_s;
    logic [31:0]              roff_s, woff_s;
    logic                     rd_reg_s, rd_rom_s, rd_accept_s, rd_err_inc_s;
    logic                     wr_scratch_s, wr_clr_s;
    logic [NUM_BANKS-1:0]     rom_sel_s;
    logic [ROM_WIDTH-1:0]     rom_word_s;
    logic [31:0]              rom_ext_s;
    logic [31:0]              reg_rdata_s;
    logic                     unused_addr_bits_s;

    assign up_wack  = wack_r;
    assign up_rack  = rack_r;
    assign up_rdata = rdata_r;
    assign rom_addr = rom_addr_r;
    assign rom_rd   = rom_rd_r;

    // Bits above the bank field do not take part in decoding.
    assign unused_addr_bits_s = ^{up_raddr[ADDRESS_WIDTH-1:ROM_ADDR_BITS+3],
                                  up_waddr[ADDRESS_WIDTH-1:ROM_ADDR_BITS+3]};

    // Address decode for both buses and request classification
    always_comb begin
        rbank_s      = up_raddr[ROM_ADDR_BITS+2:ROM_ADDR_BITS];
        wbank_s      = up_waddr[ROM_ADDR_BITS+2:ROM_ADDR_BITS];
        roff_s       = {{(32-ROM_ADDR_BITS){1'b0}}, up_raddr[ROM_ADDR_BITS-1:0]};
        woff_s       = {{(32-ROM_ADDR_BITS){1'b0}}, up_waddr[ROM_ADDR_BITS-1:0]};
        rd_reg_s     = (rbank_s == 3'd0);
        rd_rom_s     = (rbank_s != 3'd0) && (rbank_s <= BANK_COUNT);
        rom_bank_s   = rbank_s - 3'd1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rom_sel_s[b] = (rom_bank_s == 3'(b));
        end
        rd_accept_s  = up_rreq && (state_r == ST_IDLE);
        // Requests while a ROM read is in flight are dropped and counted.
        rd_err_inc_s = up_rreq && ((state_r != ST_IDLE) || (!rd_reg_s && !rd_rom_s));
        wr_scratch_s = up_wreq && (wbank_s == 3'd0) && (woff_s == OFF_SCRATCH);
        wr_clr_s     = up_wreq && (wbank_s == 3'd0) && (woff_s == OFF_RD_ERR);
    end

    // ROM word of the bank captured at request time, zero-extended
    always_comb begin
        rom_word_s = rom_data[int'(sel_bank_r)*ROM_WIDTH +: ROM_WIDTH];
        rom_ext_s  = 32'(rom_word_s);
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime_r;
    logic [31:0] uptime_hi_r;

    // Free-running cycle counter
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            uptime_r <= 64'd0;
        end else begin
            uptime_r <= uptime_r + 64'd1;
        end
    end

    // High word is frozen when the low word is read, giving a coherent snapshot
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            uptime_hi_r <= 32'd0;
        end else if (rd_accept_s && rd_reg_s && (roff_s == 32'd4)) begin
            uptime_hi_r <= uptime_r[63:32];
        end else begin
            uptime_hi_r <= uptime_hi_r;
        end
    end
`endif

    // Register-space read mux
    always_comb begin
        reg_rdata_s = 32'd0;
        case (roff_s)
            32'd0:   reg_rdata_s = VERSION_WORD;
            32'd1:   reg_rdata_s = CONFIG_WORD;
            32'd2:   reg_rdata_s = scratch_r;
            32'd3:   reg_rdata_s = MAGIC_WORD;
`ifdef SYSID_UPTIME_EN
            32'd4:   reg_rdata_s = uptime_r[31:0];
            32'd5:   reg_rdata_s = uptime_hi_r;
`endif
            32'd6:   reg_rdata_s = {16'd0, rd_err_r};
            default: reg_rdata_s = 32'd0;
        endcase
    end

    // Read FSM next-state and next registered outputs
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        rack_nxt_s     = 1'b0;
        rdata_nxt_s    = 32'd0;
        rom_rd_nxt_s   = '0;
        rom_addr_nxt_s = rom_addr_r;
        sel_bank_nxt_s = sel_bank_r;
        case (state_r)
            ST_IDLE: begin
                if (up_rreq && rd_reg_s) begin
                    rack_nxt_s  = 1'b1;
                    rdata_nxt_s = reg_rdata_s;
                end else if (up_rreq && rd_rom_s) begin
                    rom_rd_nxt_s   = rom_sel_s;
                    rom_addr_nxt_s = up_raddr[ROM_ADDR_BITS-1:0];
                    sel_bank_nxt_s = rom_bank_s;
                    cnt_nxt_s      = WAIT_LOAD;
                    state_nxt_s    = ST_WAIT;
                end else if (up_rreq) begin
                    rack_nxt_s  = 1'b1;
                    rdata_nxt_s = UNMAPPED_WORD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    rack_nxt_s  = 1'b1;
                    rdata_nxt_s = rom_ext_s;
                    state_nxt_s = ST_ACK;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read FSM state and registered read-side outputs
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            rack_r     <= 1'b0;
            rdata_r    <= 32'd0;
            rom_rd_r   <= '0;
            rom_addr_r <= '0;
            sel_bank_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            rack_r     <= rack_nxt_s;
            rdata_r    <= rdata_nxt_s;
            rom_rd_r   <= rom_rd_nxt_s;
            rom_addr_r <= rom_addr_nxt_s;
            sel_bank_r <= sel_bank_nxt_s;
        end
    end

    // Write acknowledge and scratch register
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            wack_r    <= 1'b0;
            scratch_r <= 32'd0;
        end else begin
            wack_r    <= up_wreq;
            scratch_r <= wr_scratch_s ? up_wdata : scratch_r;
        end
    end

    // Saturating read-error counter; a clear beats a same-cycle increment
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            rd_err_r <= 16'd0;
        end else if (wr_clr_s) begin
            rd_err_r <= 16'd0;
        end else if (rd_err_inc_s && (rd_err_r != 16'hFFFF)) begin
            rd_err_r <= rd_err_r + 16'd1;
        end else begin
            rd_err_r <= rd_err_r;
        end
    end

endmodule

// File: tb/tb_sys_id_mbank.sv
// Self-checking bench for sys_id_mbank: directed scenarios plus randomized traffic
// compared against a behavioural model of the register map and ROM banks.

module tb_sys_id_mbank;

    localparam int RW  = 32;
    localparam int AB  = 6;
    localparam int NB  = 2;
    localparam int LAT = 3;
    localparam int AW  = 14;

    logic           up_clk = 1'b0;
    logic           up_rstn;
    logic           up_wreq;
    logic [AW-1:0]  up_waddr;
    logic [31:0]    up_wdata;
    logic           up_wack;
    logic           up_rreq;
    logic [AW-1:0]  up_raddr;
    logic [31:0]    up_rdata;
    logic           up_rack;
    logic [AB-1:0]  rom_addr;
    logic [NB-1:0]  rom_rd;
    logic [NB*RW-1:0] rom_data;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    logic [31:0] m_scratch;
    int m_err;

    always #5 up_clk = ~up_clk;

    sys_id_mbank #(
        .ROM_WIDTH(RW), .ROM_ADDR_BITS(AB), .NUM_BANKS(NB),
        .ROM_LATENCY(LAT), .ADDRESS_WIDTH(AW)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data)
    );

    function automatic logic [31:0] rom_val(input int b, input logic [AB-1:0] a);
        return {4'hA, 4'(b), 18'h0, a};
    endfunction

    // ROM banks: the addressed word appears LAT cycles after rom_rd and then holds
    logic [RW-1:0] rom_pipe [NB][LAT];
    always @(posedge up_clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int k = LAT - 1; k > 0; k--) rom_pipe[b][k] <= rom_pipe[b][k-1];
            if (rom_rd[b]) rom_pipe[b][0] <= rom_val(b, rom_addr);
        end
    end
    always_comb begin
        for (int b = 0; b < NB; b++) rom_data[b*RW +: RW] = rom_pipe[b][LAT-1];
    end

    always @(posedge up_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    function automatic logic [31:0] model_reg(input int off);
        case (off)
            0:       return 32'h00020000;
            1:       return 32'((NB << 16) | (AB << 8) | LAT);
            2:       return m_scratch;
            3:       return 32'h53594944;
            6:       return 32'(m_err);
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp,
                           input int exp_lat, input string tag);
        int n;
        int bank;
        bank = int'(addr[AB+2:AB]);
        up_raddr = addr;
        up_rreq  = 1'b1;
        tick();
        up_rreq = 1'b0;
        n = 1;
        if (bank >= 1 && bank <= NB) begin
            chk({tag, "_romrd"}, 32'(rom_rd), 32'(1 << (bank - 1)));
            chk({tag, "_romaddr"}, 32'(rom_addr), 32'(addr[AB-1:0]));
        end
        while (!up_rack && n < 12) begin
            chk({tag, "_idle0"}, up_rdata, 32'd0);
            tick();
            n++;
            if (bank >= 1 && bank <= NB && n == 2) chk({tag, "_rompulse"}, 32'(rom_rd), 32'd0);
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, up_rdata, exp);
        tick();
        chk({tag, "_rack1"}, 32'(up_rack), 32'd0);
        chk({tag, "_rd0"}, up_rdata, 32'd0);
    endtask

    task automatic model_read(input logic [AW-1:0] addr, input string tag);
        int bank;
        bank = int'(addr[AB+2:AB]);
        if (bank == 0) begin
            do_read(addr, model_reg(int'(addr[AB-1:0])), 1, tag);
        end else if (bank <= NB) begin
            do_read(addr, rom_val(bank - 1, addr[AB-1:0]), LAT + 2, tag);
        end else begin
            if (m_err < 65535) m_err++;
            do_read(addr, 32'hDEADDEAD, 1, tag);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data);
        up_waddr = addr;
        up_wdata = data;
        up_wreq  = 1'b1;
        tick();
        up_wreq = 1'b0;
        chk("wack", 32'(up_wack), 32'd1);
        if (addr[AB+2:AB] == 3'd0 && addr[AB-1:0] == 6'd2) m_scratch = data;
        if (addr[AB+2:AB] == 3'd0 && addr[AB-1:0] == 6'd6) m_err = 0;
        tick();
        chk("wack_pulse", 32'(up_wack), 32'd0);
    endtask

    task automatic apply_reset();
        up_rstn  = 1'b0;
        up_wreq  = 1'b1;
        up_waddr = 14'h002;
        up_wdata = 32'hFFFF_FFFF;
        up_rreq  = 1'b1;
        up_raddr = 14'h045;
        tick();
        tick();
        chk("rst_wack", 32'(up_wack), 32'd0);
        chk("rst_rack", 32'(up_rack), 32'd0);
        chk("rst_rdata", up_rdata, 32'd0);
        chk("rst_romrd", 32'(rom_rd), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'd0);
        up_wreq   = 1'b0;
        up_rreq   = 1'b0;
        up_rstn   = 1'b1;
        m_scratch = 32'd0;
        m_err     = 0;
        tick();
    endtask

    initial begin
        int n;
        int extra;
        int extra_rd;
        int op;
        int off;
        logic [31:0] d;
        logic [31:0] old;
        logic [31:0] lo1;
        logic [31:0] lo2;
        int unsigned c1;
        int unsigned c2;

        up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0;
        up_waddr = '0; up_raddr = '0; up_wdata = '0;
        apply_reset();

        model_read(14'h000, "version");
        model_read(14'h001, "config");
        model_read(14'h003, "magic");
        model_read(14'h002, "scratch_rst");
        do_write(14'h002, 32'hA5A5_5A5A);
        model_read(14'h002, "scratch_wr");
        apply_reset();
        model_read(14'h002, "scratch_after_rst");

        model_read(14'h045, "rom_b0w5");
        model_read(14'h085, "rom_b1w5");
        model_read(14'h0C0, "unmapped");
        model_read(14'h006, "rd_err_one");
        do_write(14'h006, 32'h1234_5678);
        model_read(14'h006, "rd_err_clr");

        // Second request while the first ROM read is waiting
        up_raddr = 14'h047; up_rreq = 1'b1;
        tick();
        n = 1;
        up_raddr = 14'h088;
        tick();
        up_rreq = 1'b0;
        n = 2;
        if (m_err < 65535) m_err++;
        extra_rd = 0;
        while (!up_rack && n < 12) begin
            if (rom_rd[1]) extra_rd++;
            tick();
            n++;
        end
        chk("busy_lat", 32'(n), 32'(LAT + 2));
        chk("busy_data", up_rdata, rom_val(0, 6'd7));
        extra = 0;
        repeat (LAT + 4) begin
            tick();
            if (up_rack) extra++;
            if (rom_rd != '0) extra_rd++;
        end
        chk("busy_no_rack", 32'(extra), 32'd0);
        chk("busy_no_romrd", 32'(extra_rd), 32'd0);
        model_read(14'h006, "busy_rd_err");

        // Reset while a ROM read is outstanding
        up_raddr = 14'h049; up_rreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        tick();
        up_rstn = 1'b0;
        tick();
        chk("midrst_rack", 32'(up_rack), 32'd0);
        chk("midrst_romrd", 32'(rom_rd), 32'd0);
        up_rstn = 1'b1; m_scratch = 32'd0; m_err = 0;
        extra = 0;
        repeat (LAT + 4) begin
            tick();
            if (up_rack) extra++;
        end
        chk("midrst_no_rack", 32'(extra), 32'd0);
        model_read(14'h000, "midrst_next");

        // Same-cycle read and write of scratch returns the old value
        do_write(14'h002, 32'h0BAD_F00D);
        old = m_scratch;
        up_raddr = 14'h002; up_rreq = 1'b1;
        up_waddr = 14'h002; up_wdata = 32'h1357_9BDF; up_wreq = 1'b1;
        tick();
        up_rreq = 1'b0; up_wreq = 1'b0;
        chk("rw_rack", 32'(up_rack), 32'd1);
        chk("rw_old", up_rdata, old);
        chk("rw_wack", 32'(up_wack), 32'd1);
        m_scratch = 32'h1357_9BDF;
        tick();
        model_read(14'h002, "rw_new");

        // Clear and increment of RD_ERR in the same cycle
        model_read(14'h1C0, "unmapped7");
        up_raddr = 14'h100; up_rreq = 1'b1;
        up_waddr = 14'h006; up_wreq = 1'b1;
        tick();
        up_rreq = 1'b0; up_wreq = 1'b0;
        chk("clrwin_data", up_rdata, 32'hDEADDEAD);
        m_err = 0;
        tick();
        model_read(14'h006, "clrwin_err");

`ifdef SYSID_UPTIME_EN
        apply_reset();
        do_read(14'h005, 32'd0, 1, "shadow_rst");
        up_raddr = 14'h004; up_rreq = 1'b1; c1 = cyc;
        tick();
        up_rreq = 1'b0;
        chk("up_lo1_rack", 32'(up_rack), 32'd1);
        lo1 = up_rdata;
        tick();
        do_read(14'h005, 32'd0, 1, "up_hi1");
        repeat ($urandom_range(3, 40)) tick();
        up_raddr = 14'h004; up_rreq = 1'b1; c2 = cyc;
        tick();
        up_rreq = 1'b0;
        chk("up_lo2_rack", 32'(up_rack), 32'd1);
        lo2 = up_rdata;
        tick();
        do_read(14'h005, 32'd0, 1, "up_hi2");
        chk("up_delta", lo2 - lo1, 32'(c2 - c1));
`else
        do_read(14'h004, 32'd0, 1, "uptime_lo_off");
        do_read(14'h005, 32'd0, 1, "uptime_hi_off");
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    off = int'($urandom_range(0, 9));
`ifdef SYSID_UPTIME_EN
                    if (off == 4 || off == 5) off = 7;
`endif
                    model_read(14'(off), "rnd_reg");
                end
                1: begin
                    d = $urandom;
                    do_write(14'h002, d);
                end
                2: begin
                    d = $urandom;
                    do_write(14'h006, d);
                end
                3: model_read(14'((int'($urandom_range(NB + 1, 7)) << AB) | int'($urandom_range(0, 63))), "rnd_unmap");
                4: model_read(14'((int'($urandom_range(1, NB)) << AB) | int'($urandom_range(0, 63))), "rnd_rom");
                default: begin
                    d = $urandom;
                    do_write(14'($urandom_range(0, 511)), d);
                end
            endcase
        end
        model_read(14'h002, "final_scratch");
        model_read(14'h006, "final_rd_err");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
